mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester round-robin arbiter and sequencer for the 256 × 16 single-port memory. It has synchronous write and combinational read. Two independent clients (port A, port B) issue read/write commands with a req/gnt handshake. The block serialises them onto the single memory port, one access per cycle, and returns registered read data to the issuing port. It sits between the clients and the memory instance and is the only driver of the memory's address, data and write-enable.

## Interface
Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, memory word width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  port requests a memory access; held until granted
- a_we / b_we  in  1  1 = write, 0 = read; stable while req is high
- a_addr / b_addr  in  ADDR_W  access address
- a_wdata / b_wdata  in  DATA_W  write data (ignored for reads)
- a_gnt / b_gnt  out  1  combinational; command transfers on a cycle where req & gnt
- a_rvalid / b_rvalid  out  1  one-cycle pulse, read data valid
- a_rdata / b_rdata  out  DATA_W  registered read data; holds the last value between pulses
- mem_addr  out  ADDR_W  to memory address bits (bit 0 = addr0 … bit 7 = addr7)
- mem_data  out  DATA_W  to memory write data
- mem_wen  out  1  to memory write enable
- mem_qout  in  DATA_W  from memory combinational read data

## Operation
- Arbitration is combinational from a_req, b_req and the registered priority pointer `prio` (0 = A favoured, 1 = B favoured).
  - Only one port requesting: that port gets gnt.
  - Both requesting: the favoured port gets gnt.
  - At most one gnt is high per cycle.
- On a transfer edge:
  - `prio` flips to favour the other port (B after an A grant, A after a B grant).
  - The command is captured into the stage-1 registers: s1_valid, s1_port, s1_we, s1_addr, s1_wdata.
- No transfer: s1_valid ← 0 and `prio` holds.
- The arbiter is never busy. gnt depends only on req and `prio`, giving throughput of one access per cycle.
- Stage 1 drives the memory:
  - mem_addr = s1_addr and mem_data = s1_wdata, held at last value when idle.
  - mem_wen = s1_valid & s1_we.
- Stage 1 read (s1_valid & !s1_we):
  - mem_qout is captured into the issuing port's rdata register.
  - That port's rvalid pulses the next cycle.
  - The other port's rdata and rvalid are unaffected.
- Stage 1 write: no rvalid is generated.
- All outputs are registered except gnt.

## Timing
- Transfer at edge N. Memory access occurs during cycle N+1 (write commits at edge N+1). For reads, rvalid/rdata appear after edge N+1. Read latency is 2 edges from the transfer edge.
- Back-to-back transfers are allowed every cycle, from the same or alternating ports.
- Write then read of the same address on consecutive transfers: the read returns the new data, because the write commits at the edge where the read enters stage 1.
- Simultaneous requests on every cycle give strict alternation A, B, A, B… starting with the port favoured by `prio`.
- A port dropping req before gnt is legal; nothing is recorded.
- Reset (asynchronous, any time, including mid-access):
  - prio = 0, s1_valid = 0, mem_wen = 0.
  - mem_addr = 0, mem_data = 0.
  - a/b_rvalid = 0, a/b_rdata = 0.
  - In-flight accesses are dropped. A write in stage 1 at reset assertion does not commit.

## Structure
- Package mem_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - PORT_A = 1'b0, PORT_B = 1'b1 port-id constants.
  - The stage-1 command record type (valid, port, we, addr, wdata).
- Sub-module rr_arb2:
  - 2-way round-robin arbiter.
  - Inputs: req[1:0]. Outputs: one-hot gnt[1:0].
  - Owns the `prio` register. Updates `prio` on any grant.
- Top level holds stage 1, the memory-drive logic and the per-port read-return registers.

## Test plan
- Reset release, idle: all outputs 0, gnt low with no req. Assert rst_n low mid-write (s1_we = 1, addr 0x10, data 0xBEEF); address 0x10 is unchanged afterwards.
- A writes 0x1234 to 0x05, then A reads 0x05 on the next cycle: a_rvalid pulses 2 edges after the read transfer with a_rdata = 0x1234; b_rvalid stays 0.
- A and B both request from reset (A read 0x00, B read 0xFF, mem preloaded 0xAAAA and 0x5555): A granted first, B next cycle. a_rdata = 0xAAAA, then one cycle later b_rdata = 0x5555.
- Both held requesting for 8 cycles: grants alternate A, B, A, B… with exactly 4 each and never both gnt high.
- B writes 0xCAFE to 0x80, A reads 0x80 on the immediately following cycle: a_rdata = 0xCAFE.
- Only B requesting for 3 cycles (writes 0x01/0x02/0x03 to 0x01–0x03): b_gnt high all 3 cycles and mem_wen high 3 consecutive cycles. Then A gets the next contested grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared widths, port ids and stage-1 command record
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic              valid;
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } s1_cmd_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter, owns the priority pointer
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_prio;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  // The pointer always moves away from whichever port just won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (o_gnt[0]) begin
      r_prio <= 1'b1;
    end else if (o_gnt[1]) begin
      r_prio <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : round-robin sequencer for a single-port 256x16 memory
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_qout
);
  import mem_arb_pkg::*;

  logic [1:0] w_gnt;
  s1_cmd_t    r_s1;
  logic       r_a_rvalid;
  logic       r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic       w_s1_read;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({b_req, a_req}),
    .o_gnt (w_gnt)
  );

  assign a_gnt = w_gnt[0];
  assign b_gnt = w_gnt[1];

  // Address/data fields hold when idle so the memory bus stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else if (w_gnt[1]) begin
      r_s1 <= '{valid: 1'b1, port: PORT_B, we: b_we, addr: b_addr, wdata: b_wdata};
    end else if (w_gnt[0]) begin
      r_s1 <= '{valid: 1'b1, port: PORT_A, we: a_we, addr: a_addr, wdata: a_wdata};
    end else begin
      r_s1.valid <= 1'b0;
    end
  end

  assign mem_addr  = r_s1.addr;
  assign mem_data  = r_s1.wdata;
  assign mem_wen   = r_s1.valid & r_s1.we;
  assign w_s1_read = r_s1.valid & ~r_s1.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_s1_read & (r_s1.port == PORT_A);
      r_b_rvalid <= w_s1_read & (r_s1.port == PORT_B);
      if (w_s1_read && r_s1.port == PORT_A) begin
        r_a_rdata <= mem_qout;
      end
      if (w_s1_read && r_s1.port == PORT_B) begin
        r_b_rdata <= mem_qout;
      end
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench with a 256x16 memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wen;
  logic [15:0] a_rdata, b_rdata, mem_data, mem_qout;
  logic [7:0]  mem_addr;

  logic [15:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wen  (mem_wen),
    .mem_qout (mem_qout)
  );

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end
  assign mem_qout = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] addr, input logic [15:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},    {30'd0, a_gnt, b_gnt}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check({tag, "_rdata"},  {a_rdata, b_rdata}, 32'd0);
    check({tag, "_mem"},    {7'd0, mem_wen, mem_addr, mem_data}, 32'd0);
  endtask

  int na, nb;
  logic exp_a;
  logic both;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tick();
      pre_en = 1'b1; pre_addr = 8'(i); pre_data = 16'h0000;
    end
    tick();
    pre_en = 1'b0;
    preload(8'h00, 16'hAAAA);
    preload(8'hFF, 16'h5555);
    preload(8'h10, 16'h1111);
    rst_n = 1'b1;
    #1;
    check_idle("reset");

    // Both request from reset: A wins first, then B.
    tick();
    a_req = 1; a_we = 0; a_addr = 8'h00;
    b_req = 1; b_we = 0; b_addr = 8'hFF;
    #1;
    check("contend_a_gnt", {31'd0, a_gnt}, 1);
    check("contend_b_gnt", {31'd0, b_gnt}, 0);
    tick();
    a_req = 0;
    #1;
    check("contend_b_gnt2", {31'd0, b_gnt}, 1);
    tick();
    b_req = 0;
    check("contend_a_rvalid", {31'd0, a_rvalid}, 1);
    check("contend_a_rdata", a_rdata, 32'hAAAA);
    check("contend_b_rvalid0", {31'd0, b_rvalid}, 0);
    tick();
    check("contend_b_rvalid", {31'd0, b_rvalid}, 1);
    check("contend_b_rdata", b_rdata, 32'h5555);
    check("contend_a_hold", {15'd0, a_rvalid, a_rdata}, 32'hAAAA);

    // A write 0x05 then A read 0x05 back-to-back.
    tick();
    a_req = 1; a_we = 1; a_addr = 8'h05; a_wdata = 16'h1234;
    #1;
    check("wr_a_gnt", {31'd0, a_gnt}, 1);
    tick();
    a_we = 0;
    #1;
    check("rd_a_gnt", {31'd0, a_gnt}, 1);
    check("wr_mem_bus", {7'd0, mem_wen, mem_addr, mem_data}, {7'd0, 1'b1, 8'h05, 16'h1234});
    tick();
    a_req = 0;
    check("wr_no_rvalid", {31'd0, a_rvalid}, 0);
    tick();
    check("rd_a_rvalid", {31'd0, a_rvalid}, 1);
    check("rd_a_rdata", a_rdata, 32'h1234);
    check("rd_b_rvalid", {31'd0, b_rvalid}, 0);
    tick();
    check("rd_a_pulse", {31'd0, a_rvalid}, 0);

    // Held contention for 8 cycles; last winner was A so B goes first.
    a_req = 1; a_we = 0; a_addr = 8'h00;
    b_req = 1; b_we = 0; b_addr = 8'hFF;
    na = 0; nb = 0; exp_a = 1'b0; both = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("alt_a_gnt", {31'd0, a_gnt}, {31'd0, exp_a});
      check("alt_b_gnt", {31'd0, b_gnt}, {31'd0, ~exp_a});
      if (a_gnt) na++;
      if (b_gnt) nb++;
      if (a_gnt && b_gnt) both = 1'b1;
      exp_a = ~exp_a;
      tick();
    end
    a_req = 0; b_req = 0;
    check("alt_counts", {na[15:0], nb[15:0]}, {16'd4, 16'd4});
    check("alt_never_both", {31'd0, both}, 0);
    tick();
    tick();

    // B writes 0x80, A reads it on the very next cycle.
    b_req = 1; b_we = 1; b_addr = 8'h80; b_wdata = 16'hCAFE;
    #1;
    check("bw_b_gnt", {31'd0, b_gnt}, 1);
    tick();
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 8'h80;
    #1;
    check("ar_a_gnt", {31'd0, a_gnt}, 1);
    tick();
    a_req = 0;
    tick();
    check("ar_a_rvalid", {31'd0, a_rvalid}, 1);
    check("ar_a_rdata", a_rdata, 32'hCAFE);

    // B alone for 3 cycles, then a contested grant goes to A.
    tick();
    for (int i = 1; i <= 3; i++) begin
      b_req = 1; b_we = 1; b_addr = 8'(i); b_wdata = 16'(i);
      #1;
      check("bonly_b_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
      if (i > 1) check("bonly_wen", {31'd0, mem_wen}, 1);
      tick();
    end
    b_we = 0; b_addr = 8'hFF;
    a_req = 1; a_we = 0; a_addr = 8'h00;
    #1;
    check("bonly_wen3", {31'd0, mem_wen}, 1);
    check("post_b_contend", {30'd0, a_gnt, b_gnt}, 32'd2);
    tick();
    a_req = 0;
    tick();
    b_req = 0;
    tick();
    check("bonly_mem", {mem[1][7:0], mem[2][7:0], mem[3][7:0], 8'd0}, 32'h01020300);

    // Reset asserted while a write sits in stage 1: it must not commit.
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 16'hBEEF;
    tick();
    a_req = 0; a_we = 0; a_addr = 8'h00;
    check("rst_pre_wen", {31'd0, mem_wen}, 1);
    rst_n = 0;
    #1;
    check("rst_async_wen", {31'd0, mem_wen}, 0);
    tick();
    tick();
    check("rst_no_commit", {16'd0, mem[8'h10]}, 32'h1111);
    rst_n = 1;
    #1;
    check_idle("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
